// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: ALU control codes,
// FSM state encoding and the load-use hazard detector.
package pipe_hazard_ctrl_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b1111;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_e;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  function automatic logic load_use_hit(
    input logic       memrd,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use_rs2
  );
    return memrd && (rd != 5'd0) && ((rd == rs1) || (use_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear and count enable.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-busy freeze, multi-cycle
// multiply freeze, load-use bubble and taken-branch IF/ID flush.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_use_rs2_i,
  input  logic             idex_memrd_i,
  input  logic [4:0]       idex_rd_addr_i,
  input  logic             ex_valid_i,
  input  logic [3:0]       ex_alu_ctrl_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_o,
  output logic             exmem_bubble_o,
  output logic             mul_start_o,
  output logic             mul_done_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;
  logic       load_use;
  logic       start_raw, done_raw;

  assign load_use = load_use_hit(idex_memrd_i, idex_rd_addr_i, id_rs1_addr_i,
                                 id_rs2_addr_i, id_use_rs2_i);

  always_comb begin
    state_d        = state_q;
    mul_cnt_d      = mul_cnt_q;
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    idex_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_bubble_o = 1'b0;
    start_raw      = 1'b0;
    done_raw       = 1'b0;

    if (mem_busy_i) begin
      // Whole pipe holds; the multiply countdown freezes with it.
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      idex_write_o = 1'b0;
    end else if (state_q == ST_MUL_WAIT) begin
      mul_cnt_d = mul_cnt_q - 4'd1;
      if (mul_cnt_q > 4'd1) begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        idex_write_o   = 1'b0;
        exmem_bubble_o = 1'b1;
      end else begin
        done_raw = 1'b1;
        state_d  = ST_RUN;
      end
    end else if (ex_valid_i && (ex_alu_ctrl_i == ALU_MUL)) begin
      start_raw      = 1'b1;
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_write_o   = 1'b0;
      exmem_bubble_o = 1'b1;
      state_d        = ST_MUL_WAIT;
      mul_cnt_d      = MUL_INIT;
    end else if (load_use) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else begin
      ifid_flush_o = branch_taken_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ST_RUN;
      mul_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // An aborting reset must not announce a multiply start or completion.
  assign mul_start_o = start_raw & rst_i;
  assign mul_done_o  = done_raw & rst_i;
  assign busy_o      = (state_q == ST_MUL_WAIT);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .clr_n_i(rst_i),
    .en_i   (~pc_write_o),
    .cnt_o  (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: a 32-bit-counter instance and a
// 4-bit-counter instance share stimulus; expected control vectors are queued per step.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       use_rs2 = 1'b0, memrd = 1'b0, ex_valid = 1'b0;
  logic [3:0] alu = '0;
  logic       br = 1'b0, mbusy = 1'b0;

  logic        a_pc, a_ifid, a_flush, a_idex, a_idb, a_exb, a_start, a_done, a_busy;
  logic        b_pc, b_ifid, b_flush, b_idex, b_idb, b_exb, b_start, b_done, b_busy;
  logic [31:0] a_cnt;
  logic [3:0]  b_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_use_rs2_i(use_rs2), .idex_memrd_i(memrd), .idex_rd_addr_i(rd),
    .ex_valid_i(ex_valid), .ex_alu_ctrl_i(alu), .branch_taken_i(br), .mem_busy_i(mbusy),
    .pc_write_o(a_pc), .ifid_write_o(a_ifid), .ifid_flush_o(a_flush), .idex_write_o(a_idex),
    .idex_bubble_o(a_idb), .exmem_bubble_o(a_exb), .mul_start_o(a_start),
    .mul_done_o(a_done), .busy_o(a_busy), .stall_cnt_o(a_cnt));

  pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_use_rs2_i(use_rs2), .idex_memrd_i(memrd), .idex_rd_addr_i(rd),
    .ex_valid_i(ex_valid), .ex_alu_ctrl_i(alu), .branch_taken_i(br), .mem_busy_i(mbusy),
    .pc_write_o(b_pc), .ifid_write_o(b_ifid), .ifid_flush_o(b_flush), .idex_write_o(b_idex),
    .idex_bubble_o(b_idb), .exmem_bubble_o(b_exb), .mul_start_o(b_start),
    .mul_done_o(b_done), .busy_o(b_busy), .stall_cnt_o(b_cnt));

  // Vector order: {pc, ifid, flush, idex, idex_bubble, exmem_bubble, start, done, busy}
  localparam logic [8:0] RUN_OK    = 9'b1_1_0_1_0_0_0_0_0;
  localparam logic [8:0] LU_STALL  = 9'b0_0_0_1_1_0_0_0_0;
  localparam logic [8:0] MUL_START = 9'b0_0_0_0_0_1_1_0_0;
  localparam logic [8:0] MUL_STALL = 9'b0_0_0_0_0_1_0_0_1;
  localparam logic [8:0] MUL_DONE  = 9'b1_1_0_1_0_0_0_1_1;
  localparam logic [8:0] HOLD_RUN  = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] HOLD_MW   = 9'b0_0_0_0_0_0_0_0_1;
  localparam logic [8:0] FLUSH     = 9'b1_1_1_1_0_0_0_0_0;

  int         checks = 0;
  int         errors = 0;
  int         step_no = 0;
  logic [8:0] exp_q[$];
  logic [31:0] model32 = '0;
  logic [3:0]  model4 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, expv);
    end
  endtask

  // Inputs are already driven; queue the expectation, compare away from the edge, then
  // advance the reference stall counters across the edge.
  task automatic step(input string tag, input logic [8:0] e);
    logic [8:0] x;
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    check({tag, "_ctl"}, 32'({a_pc, a_ifid, a_flush, a_idex, a_idb, a_exb, a_start, a_done, a_busy}), 32'(x));
    check({tag, "_ctl4"}, 32'({b_pc, b_ifid, b_flush, b_idex, b_idb, b_exb, b_start, b_done, b_busy}), 32'(x));
    check({tag, "_cnt32"}, a_cnt, model32);
    check({tag, "_cnt4"}, 32'(b_cnt), 32'(model4));
    $display("step %0d %s ctl=%b cnt32=%0d cnt4=%0d", step_no, tag,
             {a_pc, a_ifid, a_flush, a_idex, a_idb, a_exb, a_start, a_done, a_busy}, a_cnt, b_cnt);
    @(posedge clk);
    if (!rst) begin
      model32 = '0;
      model4  = '0;
    end else if (!x[8]) begin
      model32 = model32 + 32'd1;
      if (model4 != 4'hF) model4 = model4 + 4'd1;
    end
    step_no++;
    #1;
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; use_rs2 = 1'b0; memrd = 1'b0;
    ex_valid = 1'b0; alu = 4'd0; br = 1'b0; mbusy = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    @(posedge clk); #1;
    step("reset", RUN_OK);
    rst = 1'b1;
    step("run_idle", RUN_OK);

    // Load-use detection
    memrd = 1'b1; rd = 5'd5; rs1 = 5'd5;
    step("lu_rs1", LU_STALL);
    memrd = 1'b0;
    step("lu_release", RUN_OK);
    memrd = 1'b1; rd = 5'd0; rs1 = 5'd0;
    step("lu_x0", RUN_OK);
    rd = 5'd7; rs1 = 5'd3; rs2 = 5'd7; use_rs2 = 1'b0;
    step("lu_rs2_unused", RUN_OK);
    use_rs2 = 1'b1;
    step("lu_rs2", LU_STALL);
    idle();

    // Multiply, MUL_LAT=4: start T0, stalls T0..T2, done T3
    ex_valid = 1'b1; alu = 4'b1111;
    step("mul_t0", MUL_START);
    step("mul_t1", MUL_STALL);
    step("mul_t2", MUL_STALL);
    step("mul_t3", MUL_DONE);
    idle();
    step("mul_after", RUN_OK);

    // mem_busy outranks a pending load-use hazard in RUN
    memrd = 1'b1; rd = 5'd9; rs1 = 5'd9; mbusy = 1'b1;
    step("busy_run", HOLD_RUN);
    idle();

    // Multiply with two busy cycles at T1: done moves to T5, no restart
    ex_valid = 1'b1; alu = 4'b1111;
    step("mb_t0", MUL_START);
    mbusy = 1'b1;
    step("mb_t1", HOLD_MW);
    step("mb_t2", HOLD_MW);
    mbusy = 1'b0;
    step("mb_t3", MUL_STALL);
    br = 1'b1;
    step("mb_t4_br", MUL_STALL);
    step("mb_t5", MUL_DONE);
    idle();

    // Branch suppressed during load-use stall, re-presented after
    memrd = 1'b1; rd = 5'd4; rs1 = 5'd4; br = 1'b1;
    step("br_in_lu", LU_STALL);
    memrd = 1'b0;
    step("br_flush", FLUSH);
    idle();

    // Reset at T1 of a multiply aborts without a done pulse
    ex_valid = 1'b1; alu = 4'b1111;
    step("rst_t0", MUL_START);
    rst = 1'b0;
    step("rst_t1", MUL_STALL);
    rst = 1'b1; idle();
    step("rst_after", RUN_OK);
    step("rst_after2", RUN_OK);

    // Continuous stall drives the 4-bit counter into saturation
    memrd = 1'b1; rd = 5'd12; rs1 = 5'd12;
    for (int i = 0; i < 20; i++) step("sat", LU_STALL);
    idle();
    step("sat_hold", RUN_OK);
    check("sat_value", 32'(b_cnt), 32'hF);
    check("cnt32_value", a_cnt, 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
